aes_spi_sequencer: RTL and testbench

//  Schedules transfers into the Spi_master/Aes pair. Arbitrates a key-load requester and a

---
 rtl/aes_spi_sequencer_pkg.sv | 21 ++
 rtl/aes_spi_sequencer_if.sv | 37 +++
 rtl/aes_spi_sequencer.sv | 131 +++++++++++++
 tb/tb_aes_spi_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_spi_sequencer_pkg.sv
// Shared types and sizing for the AES/SPI transfer sequencer.
package aes_spi_sequencer_pkg;

    localparam int unsigned NK_DEF = 4;
    localparam int unsigned BLK_W  = 128;
    localparam int unsigned WORD_W = 32;

    // Width of the data bus handed to the SPI master for a given key length.
    function automatic int unsigned data_w(input int unsigned nk);
        return BLK_W + nk * WORD_W;
    endfunction

    localparam int unsigned DATA_W = data_w(NK_DEF);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

endpackage

// File: rtl/aes_spi_sequencer_if.sv
// Request, SPI-master and status signals of the sequencer grouped as one bundle.
interface aes_spi_sequencer_if #(
    parameter int unsigned NK = aes_spi_sequencer_pkg::NK_DEF
) ();
    import aes_spi_sequencer_pkg::*;

    localparam int unsigned KEY_W = NK * WORD_W;
    localparam int unsigned DW    = data_w(NK);

    logic             key_valid;
    logic [KEY_W-1:0] key;
    logic             key_ready;
    logic             blk_valid;
    logic [BLK_W-1:0] blk;
    logic             blk_ready;
    logic             m_cs1;
    logic             m_cs2;
    logic [DW-1:0]    m_data;
    logic             m_done;
    logic             busy;
    logic             key_loaded;
    logic             err;
    logic             err_clr;

    // Sequencer side.
    modport master (
        input  key_valid, key, blk_valid, blk, m_done, err_clr,
        output key_ready, blk_ready, m_cs1, m_cs2, m_data, busy, key_loaded, err
    );

    // Requesters, SPI master and status consumer side.
    modport slave (
        output key_valid, key, blk_valid, blk, m_done, err_clr,
        input  key_ready, blk_ready, m_cs1, m_cs2, m_data, busy, key_loaded, err
    );

endinterface

// File: rtl/aes_spi_sequencer.sv
// Arbitrates key-load and plaintext-block requests and drives one SPI-master
// transfer at a time, with done/timeout handling and an enforced idle gap.
module aes_spi_sequencer
    import aes_spi_sequencer_pkg::*;
#(
    parameter int unsigned NK          = NK_DEF,
    parameter int unsigned GAP_CYC     = 4,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                clk,
    input  logic                rst,
    aes_spi_sequencer_if.master bus
);

    localparam int unsigned DW = data_w(NK);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC);

    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYC - 1);

    state_e          state_q,      state_d;
    logic [TW-1:0]   timer_q,      timer_d;
    logic            cs1_q,        cs1_d;
    logic            cs2_q,        cs2_d;
    logic [DW-1:0]   data_q,       data_d;
    logic            last_key_q,   last_key_d;
    logic            key_loaded_q, key_loaded_d;
    logic            err_q,        err_d;

    logic            grant_key_c;
    logic            grant_blk_c;

    // A key request yields to a pending block right after a key transfer.
    assign grant_key_c = (state_q == ST_IDLE) && bus.key_valid
                         && !(last_key_q && bus.blk_valid && key_loaded_q);
    assign grant_blk_c = (state_q == ST_IDLE) && !grant_key_c
                         && bus.blk_valid && key_loaded_q;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q + TW'(1);
        cs1_d        = cs1_q;
        cs2_d        = cs2_q;
        data_d       = data_q;
        last_key_d   = last_key_q;
        key_loaded_d = key_loaded_q;
        err_d        = err_q & ~bus.err_clr;

        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (grant_key_c) begin
                    data_d     = DW'(bus.key);
                    cs1_d      = 1'b1;
                    last_key_d = 1'b1;
                    state_d    = ST_XFER;
                end else if (grant_blk_c) begin
                    data_d     = DW'(bus.blk);
                    cs2_d      = 1'b1;
                    last_key_d = 1'b0;
                    state_d    = ST_XFER;
                end
            end

            // Done takes priority over a timeout landing in the same cycle.
            ST_XFER: begin
                if (bus.m_done) begin
                    cs1_d        = 1'b0;
                    cs2_d        = 1'b0;
                    key_loaded_d = key_loaded_q | cs1_q;
                    timer_d      = '0;
                    state_d      = ST_GAP;
                end else if (timer_q == TMO_LAST) begin
                    cs1_d   = 1'b0;
                    cs2_d   = 1'b0;
                    err_d   = 1'b1;
                    timer_d = '0;
                    state_d = ST_GAP;
                end
            end

            ST_GAP: begin
                cs1_d = 1'b0;
                cs2_d = 1'b0;
                if (timer_q == GAP_LAST) begin
                    timer_d = '0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                cs1_d   = 1'b0;
                cs2_d   = 1'b0;
                timer_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            cs1_q        <= 1'b0;
            cs2_q        <= 1'b0;
            data_q       <= '0;
            last_key_q   <= 1'b0;
            key_loaded_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            cs1_q        <= cs1_d;
            cs2_q        <= cs2_d;
            data_q       <= data_d;
            last_key_q   <= last_key_d;
            key_loaded_q <= key_loaded_d;
            err_q        <= err_d;
        end
    end

    assign bus.key_ready  = grant_key_c;
    assign bus.blk_ready  = grant_blk_c;
    assign bus.m_cs1      = cs1_q;
    assign bus.m_cs2      = cs2_q;
    assign bus.m_data     = data_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.key_loaded = key_loaded_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_aes_spi_sequencer.sv
// Directed bench for aes_spi_sequencer: one long-timeout instance for the main
// flows and a TIMEOUT_CYC=64 instance for the abort path.
module tb_aes_spi_sequencer;
    import aes_spi_sequencer_pkg::*;

    localparam int unsigned NK      = 4;
    localparam int unsigned GAP_CYC = 4;

    localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY1 = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    localparam logic [127:0] BLK0 = 128'h00112233445566778899aabbccddeeff;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    aes_spi_sequencer_if #(.NK(NK)) bus   ();
    aes_spi_sequencer_if #(.NK(NK)) bus_t ();

    aes_spi_sequencer #(.NK(NK), .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(4096)) u_dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus.master)
    );

    aes_spi_sequencer #(.NK(NK), .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(64)) u_dut_t (
        .clk (clk),
        .rst (rst_n),
        .bus (bus_t.master)
    );

    // Runs k XFER cycles from the current (first) one, raising done in the k-th.
    task automatic xfer_main(input int k, output int hi1, output int hi2);
        hi1 = 0;
        hi2 = 0;
        for (int i = 1; i <= k; i++) begin
            if (bus.m_cs1 === 1'b1) hi1++;
            if (bus.m_cs2 === 1'b1) hi2++;
            if (i == k) bus.m_done = 1'b1;
            @(negedge clk);
        end
        bus.m_done = 1'b0;
    endtask

    task automatic gap_main(output int bad);
        bad = 0;
        for (int i = 0; i < int'(GAP_CYC); i++) begin
            #1;
            if (bus.m_cs1 !== 1'b0 || bus.m_cs2 !== 1'b0 || bus.busy !== 1'b1 ||
                bus.key_ready !== 1'b0 || bus.blk_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        #1;
        if (bus.busy !== 1'b0) bad++;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_vec++;
        if ({bus.m_cs1, bus.m_cs2, bus.busy, bus.key_loaded, bus.err, bus.key_ready, bus.blk_ready} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b, want 0000000",
                     {bus.m_cs1, bus.m_cs2, bus.busy, bus.key_loaded, bus.err, bus.key_ready, bus.blk_ready});
        end
        n_vec++;
        if (bus.m_data !== '0 || bus_t.m_data !== '0) begin
            n_err++;
            $display("FAIL reset_data: got %h / %h, want 0", bus.m_data, bus_t.m_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_blk_before_key();
        int bad;
        bad = 0;
        bus.blk       = BLK0;
        bus.blk_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (bus.blk_ready !== 1'b0 || bus.m_cs1 !== 1'b0 || bus.m_cs2 !== 1'b0 || bus.busy !== 1'b0) bad++;
            @(negedge clk);
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL blk_before_key: %0d cycles granted/selected, want 0", bad);
        end
    endtask

    task automatic test_key_then_blk();
        int hi1, hi2, bad;
        bus.key       = KEY0;
        bus.key_valid = 1'b1;
        #1;
        n_vec++;
        if (bus.key_ready !== 1'b1 || bus.blk_ready !== 1'b0) begin
            n_err++;
            $display("FAIL key_grant: key_ready=%b blk_ready=%b, want 1 0", bus.key_ready, bus.blk_ready);
        end
        @(negedge clk);
        bus.key_valid = 1'b0;
        n_vec++;
        if (bus.m_data !== {128'h0, KEY0}) begin
            n_err++;
            $display("FAIL key_data: got %h, want %h", bus.m_data, {128'h0, KEY0});
        end
        xfer_main(160, hi1, hi2);
        n_vec++;
        if (hi1 != 160 || hi2 != 0) begin
            n_err++;
            $display("FAIL key_cs1_len: cs1=%0d cs2=%0d cycles, want 160 0", hi1, hi2);
        end
        n_vec++;
        if (bus.key_loaded !== 1'b1 || bus.m_cs1 !== 1'b0 || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL key_done: key_loaded=%b cs1=%b busy=%b, want 1 0 1", bus.key_loaded, bus.m_cs1, bus.busy);
        end
        gap_main(bad);
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL key_gap: %0d bad gap cycles, want 0", bad);
        end
        n_vec++;
        if (bus.blk_ready !== 1'b1) begin
            n_err++;
            $display("FAIL blk_grant: blk_ready=%b, want 1", bus.blk_ready);
        end
        @(negedge clk);
        bus.blk_valid = 1'b0;
        n_vec++;
        if (bus.m_cs2 !== 1'b1 || bus.m_cs1 !== 1'b0 || bus.m_data !== {128'h0, BLK0}) begin
            n_err++;
            $display("FAIL blk_xfer: cs1=%b cs2=%b data=%h, want 0 1 %h", bus.m_cs1, bus.m_cs2, bus.m_data, {128'h0, BLK0});
        end
        xfer_main(7, hi1, hi2);
        gap_main(bad);
        n_vec++;
        if (hi2 != 7 || hi1 != 0 || bad != 0) begin
            n_err++;
            $display("FAIL blk_len: cs2=%0d cs1=%0d gapbad=%0d, want 7 0 0", hi2, hi1, bad);
        end
    endtask

    task automatic test_back_to_back();
        int   hi1, hi2, bad;
        logic exp_key;
        bus.key       = KEY1;
        bus.blk       = BLK0;
        bus.key_valid = 1'b1;
        bus.blk_valid = 1'b1;
        for (int g = 0; g < 4; g++) begin
            exp_key = ((g % 2) == 0);
            #1;
            n_vec++;
            if (bus.key_ready !== exp_key || bus.blk_ready !== ~exp_key) begin
                n_err++;
                $display("FAIL b2b_grant%0d: key_ready=%b blk_ready=%b, want %b %b",
                         g, bus.key_ready, bus.blk_ready, exp_key, ~exp_key);
            end
            @(negedge clk);
            if (g == 3) begin
                bus.key_valid = 1'b0;
                bus.blk_valid = 1'b0;
            end
            xfer_main(5, hi1, hi2);
            gap_main(bad);
            n_vec++;
            if (hi1 != (exp_key ? 5 : 0) || hi2 != (exp_key ? 0 : 5) || bad != 0) begin
                n_err++;
                $display("FAIL b2b_xfer%0d: cs1=%0d cs2=%0d gapbad=%0d, want %0d %0d 0",
                         g, hi1, hi2, bad, exp_key ? 5 : 0, exp_key ? 0 : 5);
            end
        end
    endtask

    task automatic test_timeout();
        int hi;
        hi                = 0;
        bus_t.key         = KEY1;
        bus_t.key_valid   = 1'b1;
        #1;
        @(negedge clk);
        bus_t.key_valid = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (bus_t.m_cs1 === 1'b1) hi++;
            if (i == 63) bus_t.err_clr = 1'b1;
            @(negedge clk);
        end
        bus_t.err_clr = 1'b0;
        n_vec++;
        if (hi != 64 || bus_t.m_cs1 !== 1'b0 || bus_t.err !== 1'b1 || bus_t.key_loaded !== 1'b0) begin
            n_err++;
            $display("FAIL timeout: cs1_cycles=%0d cs1=%b err=%b key_loaded=%b, want 64 0 1 0",
                     hi, bus_t.m_cs1, bus_t.err, bus_t.key_loaded);
        end
        @(negedge clk);
        n_vec++;
        if (bus_t.err !== 1'b1) begin
            n_err++;
            $display("FAIL err_sticky: err=%b, want 1", bus_t.err);
        end
        bus_t.err_clr = 1'b1;
        @(negedge clk);
        bus_t.err_clr = 1'b0;
        n_vec++;
        if (bus_t.err !== 1'b0) begin
            n_err++;
            $display("FAIL err_clr: err=%b, want 0", bus_t.err);
        end
        repeat (2) @(negedge clk);
        n_vec++;
        if (bus_t.busy !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_gap: busy=%b, want 0", bus_t.busy);
        end
        bus_t.key_valid = 1'b1;
        #1;
        @(negedge clk);
        bus_t.key_valid = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (i == 63) bus_t.m_done = 1'b1;
            @(negedge clk);
        end
        bus_t.m_done = 1'b0;
        n_vec++;
        if (bus_t.err !== 1'b0 || bus_t.key_loaded !== 1'b1 || bus_t.m_cs1 !== 1'b0) begin
            n_err++;
            $display("FAIL done_vs_timeout: err=%b key_loaded=%b cs1=%b, want 0 1 0",
                     bus_t.err, bus_t.key_loaded, bus_t.m_cs1);
        end
    endtask

    task automatic test_done_ignored();
        int hi1, hi2, bad;
        bus.m_done = 1'b1;
        @(negedge clk);
        bus.m_done = 1'b0;
        n_vec++;
        if (bus.busy !== 1'b0 || bus.m_cs1 !== 1'b0 || bus.m_cs2 !== 1'b0) begin
            n_err++;
            $display("FAIL done_in_idle: busy=%b cs1=%b cs2=%b, want 0 0 0", bus.busy, bus.m_cs1, bus.m_cs2);
        end
        bus.key       = KEY0;
        bus.key_valid = 1'b1;
        #1;
        @(negedge clk);
        bus.key_valid = 1'b0;
        xfer_main(3, hi1, hi2);
        bus.m_done = 1'b1;
        gap_main(bad);
        bus.m_done = 1'b0;
        n_vec++;
        if (bad != 0 || hi1 != 3) begin
            n_err++;
            $display("FAIL done_in_gap: gapbad=%0d cs1=%0d, want 0 3", bad, hi1);
        end
    endtask

    task automatic test_reset_mid_xfer();
        int hi1, hi2, bad;
        bus.key       = KEY0;
        bus.key_valid = 1'b1;
        #1;
        @(negedge clk);
        bus.key_valid = 1'b0;
        n_vec++;
        if (bus.m_cs1 !== 1'b1 || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset: cs1=%b busy=%b, want 1 1", bus.m_cs1, bus.busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.m_cs1, bus.m_cs2, bus.busy, bus.key_loaded} !== 4'b0 || bus.m_data !== '0) begin
            n_err++;
            $display("FAIL async_reset: cs1/cs2/busy/key_loaded=%b data=%h, want 0000 0",
                     {bus.m_cs1, bus.m_cs2, bus.busy, bus.key_loaded}, bus.m_data);
        end
        @(negedge clk);
        rst_n         = 1'b1;
        bus.blk       = BLK0;
        bus.blk_valid = 1'b1;
        bad           = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.blk_ready !== 1'b0 || bus.m_cs2 !== 1'b0) bad++;
            @(negedge clk);
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL blk_after_reset: %0d grant cycles, want 0", bad);
        end
        bus.key_valid = 1'b1;
        #1;
        n_vec++;
        if (bus.key_ready !== 1'b1 || bus.blk_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rekey_grant: key_ready=%b blk_ready=%b, want 1 0", bus.key_ready, bus.blk_ready);
        end
        @(negedge clk);
        bus.key_valid = 1'b0;
        xfer_main(3, hi1, hi2);
        gap_main(bad);
        n_vec++;
        if (bus.blk_ready !== 1'b1 || bad != 0) begin
            n_err++;
            $display("FAIL blk_after_rekey: blk_ready=%b gapbad=%0d, want 1 0", bus.blk_ready, bad);
        end
        @(negedge clk);
        bus.blk_valid = 1'b0;
        xfer_main(3, hi1, hi2);
        gap_main(bad);
    endtask

    initial begin
        bus.key_valid   = 1'b0;
        bus.key         = '0;
        bus.blk_valid   = 1'b0;
        bus.blk         = '0;
        bus.m_done      = 1'b0;
        bus.err_clr     = 1'b0;
        bus_t.key_valid = 1'b0;
        bus_t.key       = '0;
        bus_t.blk_valid = 1'b0;
        bus_t.blk       = '0;
        bus_t.m_done    = 1'b0;
        bus_t.err_clr   = 1'b0;

        test_reset();
        test_blk_before_key();
        test_key_then_blk();
        test_back_to_back();
        test_timeout();
        test_done_ignored();
        test_reset_mid_xfer();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
